// File: rtl/overdrive_sequencer_pkg.sv
// Shared effects package: sequencer FSM states and the fixed-point unity constant.
package overdrive_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        CU   = 2'd2,
        OUT  = 2'd3
    } state_e;

    localparam int DEFAULT_BITS_PER_LEVEL = 12;

    // Unity in a fixed-point format with bpl fractional bits.
    function automatic longint fxp_one(input int bpl);
        return longint'(1) << bpl;
    endfunction

    localparam longint ONE = fxp_one(DEFAULT_BITS_PER_LEVEL);

endpackage

// File: rtl/overdrive_sequencer_fixed_multiply.sv
// Signed fixed-point multiply: full-width product, rescaled by the fractional bits.
module fixed_multiply #(
    parameter int bits_per_level = 12,
    parameter int fxp_size       = 32
) (
    input  logic signed [fxp_size-1:0] i_a,
    input  logic signed [fxp_size-1:0] i_b,
    output logic signed [fxp_size-1:0] o_p
);

    logic signed [2*fxp_size-1:0] full_prod;

    always_comb begin
        full_prod = (2*fxp_size)'(i_a) * (2*fxp_size)'(i_b);
        o_p       = fxp_size'(full_prod >>> bits_per_level);
    end

endmodule

// File: rtl/overdrive_sequencer.sv
// Two-channel round-robin soft-clip sequencer: y = (3x - x^3)/2 using one shared multiplier.
module overdrive_sequencer
    import overdrive_sequencer_pkg::*;
#(
    parameter int bits_per_level = 12,
    parameter int fxp_size       = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic                i_valid0,
    input  logic                i_valid1,
    input  logic [fxp_size-1:0] i_sample0,
    input  logic [fxp_size-1:0] i_sample1,
    output logic                o_ready0,
    output logic                o_ready1,
    output logic                o_valid,
    output logic [fxp_size-1:0] o_sample,
    output logic                o_channel,
    input  logic                i_ready
);

    localparam logic signed [fxp_size-1:0] one_c = fxp_size'(fxp_one(bits_per_level));

    state_e state_q, state_d;
    logic signed [fxp_size-1:0] x_q, x_d;
    logic signed [fxp_size-1:0] sq_q, sq_d;
    logic signed [fxp_size-1:0] cu_q, cu_d;
    logic ch_q, ch_d;
    logic en_q, en_d;
    logic last_q, last_d;

    logic grant_valid;
    logic grant_ch;
    logic ready0;
    logic ready1;
    logic signed [fxp_size-1:0] mul_a;
    logic signed [fxp_size-1:0] mul_b;
    logic signed [fxp_size-1:0] mul_p;
    logic signed [fxp_size+1:0] three_x;
    logic signed [fxp_size+1:0] diff;
    logic signed [fxp_size-1:0] result;

    // On a tie the channel not served last wins; a lone requester always wins.
    always_comb begin
        grant_valid = i_valid0 | i_valid1;
        grant_ch    = (i_valid0 & i_valid1) ? ~last_q : i_valid1;
    end

    always_comb begin
        mul_a = x_q;
        mul_b = x_q;
        if (state_q == CU) begin
            mul_a = sq_q;
        end
    end

    fixed_multiply #(
        .bits_per_level(bits_per_level),
        .fxp_size      (fxp_size)
    ) u_mul (
        .i_a(mul_a),
        .i_b(mul_b),
        .o_p(mul_p)
    );

    always_comb begin
        three_x = ((fxp_size+2)'(x_q) <<< 1) + (fxp_size+2)'(x_q);
        diff    = three_x - (fxp_size+2)'(cu_q);
        result  = fxp_size'(diff >>> 1);
        if (!en_q) begin
            result = x_q;
        end else if (x_q >= one_c) begin
            result = one_c;
        end else if (x_q <= -one_c) begin
            result = -one_c;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        sq_d    = sq_q;
        cu_d    = cu_q;
        ch_d    = ch_q;
        en_d    = en_q;
        last_d  = last_q;
        ready0  = 1'b0;
        ready1  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    ready0  = ~grant_ch;
                    ready1  = grant_ch;
                    x_d     = grant_ch ? i_sample1 : i_sample0;
                    ch_d    = grant_ch;
                    en_d    = i_enable;
                    last_d  = grant_ch;
                    state_d = SQ;
                end
            end
            SQ: begin
                sq_d    = mul_p;
                state_d = CU;
            end
            CU: begin
                cu_d    = mul_p;
                state_d = OUT;
            end
            OUT: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced low while reset is held so nothing partial escapes.
    always_comb begin
        o_ready0  = ready0 & ~i_rst;
        o_ready1  = ready1 & ~i_rst;
        o_valid   = (state_q == OUT) & ~i_rst;
        o_sample  = o_valid ? result : '0;
        o_channel = o_valid & ch_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            sq_q    <= '0;
            cu_q    <= '0;
            ch_q    <= 1'b0;
            en_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            sq_q    <= sq_d;
            cu_q    <= cu_d;
            ch_q    <= ch_d;
            en_q    <= en_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_overdrive_sequencer.sv
// Directed self-checking bench for overdrive_sequencer with hand-computed soft-clip results.
module tb_overdrive_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         valid0;
    logic         valid1;
    logic [W-1:0] sample0;
    logic [W-1:0] sample1;
    logic         ready0;
    logic         ready1;
    logic         out_valid;
    logic [W-1:0] out_sample;
    logic         out_channel;
    logic         ready_in;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    overdrive_sequencer dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_enable (enable),
        .i_valid0 (valid0),
        .i_valid1 (valid1),
        .i_sample0(sample0),
        .i_sample1(sample1),
        .o_ready0 (ready0),
        .o_ready1 (ready1),
        .o_valid  (out_valid),
        .o_sample (out_sample),
        .o_channel(out_channel),
        .i_ready  (ready_in)
    );

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint sv(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    // One full transaction from IDLE: grant, SQ, CU, OUT, back to IDLE.
    task automatic applyStimulus(input bit ch, input int x, input bit en, input int expected,
                                 input string tag, input bit flipEnable);
        if (ch) begin
            valid1  = 1'b1;
            sample1 = x;
        end else begin
            valid0  = 1'b1;
            sample0 = x;
        end
        enable   = en;
        ready_in = 1'b1;
        #1;
        checkOutput({tag, " grant"}, ch ? ready1 : ready0, 1);
        tick();
        valid0 = 1'b0;
        valid1 = 1'b0;
        if (flipEnable) enable = ~en;
        checkOutput({tag, " early valid"}, out_valid, 0);
        tick();
        tick();
        checkOutput({tag, " valid"}, out_valid, 1);
        checkOutput({tag, " sample"}, sv(out_sample), expected);
        checkOutput({tag, " channel"}, out_channel, ch);
        tick();
        checkOutput({tag, " idle"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        valid0   = 1'b1;
        valid1   = 1'b0;
        sample0  = 32'd2048;
        sample1  = '0;
        ready_in = 1'b1;
        tick();
        tick();
        checkOutput("reset valid", out_valid, 0);
        checkOutput("reset ready0", ready0, 0);
        checkOutput("reset ready1", ready1, 0);
        checkOutput("reset sample", sv(out_sample), 0);
        checkOutput("reset channel", out_channel, 0);
        rst    = 1'b0;
        valid0 = 1'b0;

        // Both channels valid: grants alternate starting with channel 0.
        valid0  = 1'b1;
        valid1  = 1'b1;
        sample0 = 32'd2048;
        sample1 = -32'sd2048;
        enable  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput($sformatf("rr%0d ready0", k), ready0, (k % 2) == 0);
            checkOutput($sformatf("rr%0d ready1", k), ready1, (k % 2) == 1);
            tick();
            checkOutput($sformatf("rr%0d busy ready", k), ready0 | ready1, 0);
            tick();
            tick();
            checkOutput($sformatf("rr%0d valid", k), out_valid, 1);
            checkOutput($sformatf("rr%0d channel", k), out_channel, k % 2);
            checkOutput($sformatf("rr%0d sample", k), sv(out_sample), (k % 2) ? -2816 : 2816);
            tick();
        end
        valid0 = 1'b0;
        valid1 = 1'b0;

        applyStimulus(1'b1, -2048, 1'b1, -2816, "neg half", 1'b0);
        applyStimulus(1'b1, 8192, 1'b1, 4096, "clip pos", 1'b0);
        applyStimulus(1'b1, -4096, 1'b1, -4096, "clip neg one", 1'b0);
        applyStimulus(1'b0, 4096, 1'b1, 4096, "pos one", 1'b0);
        applyStimulus(1'b0, 4095, 1'b1, 4096, "just below one", 1'b0);
        applyStimulus(1'b0, -4095, 1'b1, -4096, "just above minus one", 1'b0);
        applyStimulus(1'b1, 1000, 1'b1, 1470, "small", 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 0, "zero", 1'b0);
        applyStimulus(1'b0, 12345, 1'b0, 12345, "bypass flip", 1'b1);
        applyStimulus(1'b1, -20000, 1'b0, -20000, "bypass neg", 1'b0);
        applyStimulus(1'b0, 2048, 1'b1, 2816, "enabled flip", 1'b1);

        // Backpressure: result must hold in OUT and no new grant may happen.
        valid0   = 1'b1;
        sample0  = 32'd2048;
        enable   = 1'b1;
        ready_in = 1'b0;
        #1;
        checkOutput("bp grant", ready0, 1);
        tick();
        valid0  = 1'b0;
        valid1  = 1'b1;
        sample1 = 32'd100;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp%0d valid", k), out_valid, 1);
            checkOutput($sformatf("bp%0d sample", k), sv(out_sample), 2816);
            checkOutput($sformatf("bp%0d channel", k), out_channel, 0);
            checkOutput($sformatf("bp%0d ready0", k), ready0, 0);
            checkOutput($sformatf("bp%0d ready1", k), ready1, 0);
            tick();
        end
        valid1   = 1'b0;
        ready_in = 1'b1;
        tick();
        checkOutput("bp release idle", out_valid, 0);

        // Reset while the sample sits in CU drops it for good.
        valid0  = 1'b1;
        sample0 = 32'd1000;
        enable  = 1'b1;
        #1;
        checkOutput("rst grant", ready0, 1);
        tick();
        valid0 = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checkOutput("rst in cu valid", out_valid, 0);
        tick();
        rst = 1'b0;
        checkOutput("rst idle valid", out_valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("rst drop%0d", k), out_valid, 0);
        end
        applyStimulus(1'b1, 2048, 1'b1, 2816, "after reset", 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
